execute_vector_multipass: RTL and testbench
===========================================

Name: execute_vector_multipass

Overview:
- Parametrised successor to the one-lane-per-thread vector execute stage.
- Executes one wavefront vector instruction on a configurable number of physical lanes (LANES ≤ THREADS), sequencing over THREADS/LANES passes.
- Whole passes whose exec slice is zero are skipped.
- Results collect in a wavefront-wide output register, presented with a valid/ready handshake to writeback.

Parameters:
THREADS, 32, threads per wavefront; power of two.
LANES, 8, physical ALU lanes; power of two; must divide THREADS.
DATA_W, 32, per-thread operand/result width.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  instruction and operands valid
in_ready  output  1  block can accept; high only in IDLE
op  input  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL_LO, 6 CMP_LT_U, 7 CNDMASK
src0  input  THREADS*DATA_W  operand A; thread t = bits [t*DATA_W +: DATA_W]
src1  input  THREADS*DATA_W  operand B
vcc_in  input  THREADS  per-thread condition for CNDMASK
exec  input  THREADS  per-thread execute mask
out_valid  output  1  result valid
out_ready  input  1  downstream accepts
vdst  output  THREADS*DATA_W  per-thread result
vdst_wb  output  THREADS  per-thread VGPR write enable
vcc_data  output  THREADS  compare result mask
vcc_wb  output  1  VCC write enable
sdst_lo  output  32  compare mask low word: vcc_data zero-extended/truncated to 32 bits
busy  output  1  state != IDLE
next_busy  output  1  next-state != IDLE

Behaviour:
- Reset is synchronous and active-high on clk.
- Reset values:
  - state IDLE; in_ready=1.
  - out_valid, vdst_wb, vcc_wb, vcc_data, sdst_lo, busy, next_busy = 0.
  - vdst = 0.
- States: IDLE, EXEC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch op, src0, src1, vcc_in, exec; clear result registers; select pass pointer.
  - Pass pointer = lowest pass p with exec[p*LANES +: LANES] != 0.
  - If exec==0, go to DONE, else go to EXEC.
- EXEC:
  - Each cycle, compute LANES threads of the current pass and register the results into the slots for that pass.
  - Then advance the pointer to the next pass with a non-zero exec slice.
  - When there are no further active passes, go to DONE.
  - Skipped passes cost zero cycles.
- DONE:
  - out_valid=1; outputs held stable while out_ready=0.
  - On out_ready, go to IDLE. A new instruction is accepted no earlier than the following cycle; there is no same-cycle turnaround.
- Latency: out_valid rises N+1 cycles after the accept edge, where N = number of active passes. When exec==0, out_valid rises 1 cycle after the accept edge.
- Lane arithmetic (DATA_W-bit, wrap-around):
  - ADD: a+b mod 2^DATA_W.
  - SUB: a-b mod 2^DATA_W.
  - AND, OR, XOR: bitwise.
  - MUL_LO: low DATA_W bits of the unsigned product.
  - CMP_LT_U: unsigned a<b → vcc bit.
  - CNDMASK: vcc_in ? b : a.
- Masking:
  - Threads with exec=0 never write: vdst slot=0, vdst_wb=0, vcc_data bit=0.
  - Ops 0-5 and 7: vdst_wb = latched exec; vcc_wb=0; vcc_data=0.
  - Op 6: vdst_wb=0; vdst=0; vcc_data = exec & compare; vcc_wb = |exec.
- busy = (state!=IDLE).
- next_busy = (next state != IDLE); it therefore drops in the cycle DONE is accepted.
- Operand inputs are ignored outside the accept cycle; changes to them during EXEC/DONE have no effect.
- rst asserted in EXEC or DONE: the in-flight instruction is discarded, with no out_valid pulse. Next cycle is IDLE with all outputs at their reset values.
- in_valid with in_ready=0 is not accepted; the upstream stage holds.

Test Plan:
- THREADS=32, LANES=8, op=ADD, exec=0xFFFFFFFF, src0[t]=t, src1[t]=0xFFFFFFFF → out_valid 5 cycles after accept; vdst[0]=0xFFFFFFFF, vdst[t]=t-1 for t≥1; vdst_wb=0xFFFFFFFF; vcc_wb=0.
- Pass skip: op=XOR, exec=0x00FF0000 → busy for exactly 2 cycles then DONE, i.e. 1 active pass and out_valid at accept+2. Only threads 16-23 written; vdst_wb=0x00FF0000; all other vdst slots 0.
- Empty exec: exec=0 → out_valid at accept+1; vdst_wb=0; vcc_wb=0; vdst all zero.
- Compare: op=CMP_LT_U, src0[t]=t, src1[t]=16, exec=0x0000FFFF → vcc_data=0x0000FFFF; sdst_lo=0x0000FFFF; vcc_wb=1; vdst_wb=0.
- Backpressure and handshake:
  - Hold out_ready=0 for 10 cycles in DONE, then pulse 1 → outputs constant throughout; busy=1, in_ready=0 while held.
  - next_busy=0 in the accept cycle; in_ready=1 the next cycle; a second in_valid is accepted then.
- Edge ops and reset:
  - MUL_LO with 0xFFFFFFFF*0xFFFFFFFF → 0x00000001.
  - CNDMASK with vcc_in=0xAAAAAAAA → odd threads take src1.
  - rst asserted in the 2nd EXEC cycle → no out_valid ever; next cycle in_ready=1, busy=0.

Source files
------------

// File: rtl/execute_vector_multipass.sv
// Multi-pass vector execute stage: runs one wavefront instruction over LANES physical
// lanes, visiting only passes with a non-zero exec slice, then holds results for writeback.
module execute_vector_multipass #(
  parameter int THREADS = 32,
  parameter int LANES   = 8,
  parameter int DATA_W  = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2:0]                  op,
  input  logic [THREADS*DATA_W-1:0]   src0,
  input  logic [THREADS*DATA_W-1:0]   src1,
  input  logic [THREADS-1:0]          vcc_in,
  input  logic [THREADS-1:0]          exec,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [THREADS*DATA_W-1:0]   vdst,
  output logic [THREADS-1:0]          vdst_wb,
  output logic [THREADS-1:0]          vcc_data,
  output logic                        vcc_wb,
  output logic [31:0]                 sdst_lo,
  output logic                        busy,
  output logic                        next_busy
);

  localparam int PASSES = THREADS / LANES;
  localparam int PW     = (PASSES > 1) ? $clog2(PASSES) : 1;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                         OP_XOR = 3'd4, OP_MUL = 3'd5, OP_CMP = 3'd6, OP_CND = 3'd7;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]                op_q;
  logic [THREADS*DATA_W-1:0] src0_q, src1_q;
  logic [THREADS-1:0]        vcc_q, exec_q;
  logic [PW-1:0]             pass_q;
  logic [PW:0]               first_hit, next_hit;

  logic [DATA_W-1:0] lane_res [LANES];
  logic [LANES-1:0]  lane_lt, lane_ex;

  // Lowest pass index >= start with a non-zero exec slice; MSB flags a hit.
  function automatic logic [PW:0] find_pass(input logic [THREADS-1:0] ex, input int start);
    logic [PW:0] hit;
    hit = '0;
    for (int p = PASSES - 1; p >= 0; p--)
      if (p >= start && ex[p*LANES +: LANES] != '0) hit = {1'b1, PW'(p)};
    return hit;
  endfunction

  function automatic logic [DATA_W-1:0] alu(input logic [2:0] f, input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b, input logic c);
    case (f)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_MUL:  return a * b;
      OP_CND:  return c ? b : a;
      default: return '0;
    endcase
  endfunction

  always_comb begin
    first_hit = find_pass(exec, 0);
    next_hit  = find_pass(exec_q, int'(pass_q) + 1);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = first_hit[PW] ? EXEC : DONE;
      EXEC:    if (!next_hit[PW]) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    next_busy = !rst && (state_nxt != IDLE);
  end

  // Stage p0: operand capture on accept; operands are data only and carry no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      op_q   <= op;
      src0_q <= src0;
      src1_q <= src1;
      vcc_q  <= vcc_in;
      exec_q <= exec;
    end
  end

  // Stage p1: per-lane compute for the current pass.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_res[l] = alu(op_q, src0_q[(int'(pass_q)*LANES + l)*DATA_W +: DATA_W],
                        src1_q[(int'(pass_q)*LANES + l)*DATA_W +: DATA_W],
                        vcc_q[int'(pass_q)*LANES + l]);
      lane_lt[l]  = src0_q[(int'(pass_q)*LANES + l)*DATA_W +: DATA_W]
                  < src1_q[(int'(pass_q)*LANES + l)*DATA_W +: DATA_W];
      lane_ex[l]  = exec_q[int'(pass_q)*LANES + l];
    end
  end

  // Stage p2: result slots for the pass, plus pass pointer advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      vdst     <= '0;
      vdst_wb  <= '0;
      vcc_data <= '0;
      vcc_wb   <= 1'b0;
      pass_q   <= '0;
    end else if (state == IDLE && in_valid) begin
      vdst     <= '0;
      vdst_wb  <= '0;
      vcc_data <= '0;
      vcc_wb   <= 1'b0;
      pass_q   <= first_hit[PW-1:0];
    end else if (state == EXEC) begin
      for (int l = 0; l < LANES; l++) begin
        vdst[(int'(pass_q)*LANES + l)*DATA_W +: DATA_W] <=
          (lane_ex[l] && op_q != OP_CMP) ? lane_res[l] : '0;
        vdst_wb[int'(pass_q)*LANES + l]  <= lane_ex[l] && (op_q != OP_CMP);
        vcc_data[int'(pass_q)*LANES + l] <= lane_ex[l] && (op_q == OP_CMP) && lane_lt[l];
      end
      vcc_wb <= (op_q == OP_CMP);
      pass_q <= next_hit[PW-1:0];
    end
  end

  generate
    if (THREADS >= 32) begin : g_sdst_trunc
      assign sdst_lo = vcc_data[31:0];
    end else begin : g_sdst_ext
      assign sdst_lo = {{(32-THREADS){1'b0}}, vcc_data};
    end
  endgenerate

endmodule

// File: tb/tb_execute_vector_multipass.sv
// Directed bench for execute_vector_multipass: arithmetic, pass skipping, compare,
// backpressure/handshake, edge ops and mid-flight reset.
module tb_execute_vector_multipass;
  localparam int THREADS = 32;
  localparam int LANES   = 8;
  localparam int DATA_W  = 32;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        in_valid;
  logic                        in_ready;
  logic [2:0]                  op;
  logic [THREADS*DATA_W-1:0]   src0, src1;
  logic [THREADS-1:0]          vcc_in, exec;
  logic                        out_valid;
  logic                        out_ready;
  logic [THREADS*DATA_W-1:0]   vdst;
  logic [THREADS-1:0]          vdst_wb, vcc_data;
  logic                        vcc_wb;
  logic [31:0]                 sdst_lo;
  logic                        busy, next_busy;

  int vectors = 0;
  int miscompares = 0;

  execute_vector_multipass #(.THREADS(THREADS), .LANES(LANES), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .src0(src0), .src1(src1), .vcc_in(vcc_in), .exec(exec), .out_valid(out_valid),
    .out_ready(out_ready), .vdst(vdst), .vdst_wb(vdst_wb), .vcc_data(vcc_data),
    .vcc_wb(vcc_wb), .sdst_lo(sdst_lo), .busy(busy), .next_busy(next_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] slot(input logic [THREADS*DATA_W-1:0] v, input int t);
    return v[t*DATA_W +: DATA_W];
  endfunction

  // Present one instruction for a single accept edge, then scramble operands.
  task automatic do_accept(input logic [2:0] f, input logic [THREADS*DATA_W-1:0] a,
                           input logic [THREADS*DATA_W-1:0] b, input logic [THREADS-1:0] c,
                           input logic [THREADS-1:0] ex);
    op = f; src0 = a; src1 = b; vcc_in = c; exec = ex; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int t = 0; t < THREADS; t++) begin
      src0[t*DATA_W +: DATA_W] = $urandom;
      src1[t*DATA_W +: DATA_W] = $urandom;
    end
    vcc_in = $urandom; exec = $urandom; op = 3'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic pop;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; src0 = '0; src1 = '0; vcc_in = '0; exec = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    vectors++;
    if ({in_ready, out_valid, busy, next_busy} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 1000", {in_ready, out_valid, busy, next_busy});
    end
    vectors++;
    if (vdst !== '0 || vdst_wb !== '0 || vcc_data !== '0 || vcc_wb !== 1'b0 || sdst_lo !== '0) begin
      miscompares++;
      $display("FAIL reset_data: wb=%h vcc=%h vcc_wb=%b sdst=%h", vdst_wb, vcc_data, vcc_wb, sdst_lo);
    end
  endtask

  task automatic test_add_full;
    logic [THREADS*DATA_W-1:0] a, b;
    int lat;
    for (int t = 0; t < THREADS; t++) begin
      a[t*DATA_W +: DATA_W] = DATA_W'(t);
      b[t*DATA_W +: DATA_W] = 32'hFFFF_FFFF;
    end
    do_accept(3'd0, a, b, '0, 32'hFFFF_FFFF);
    wait_valid(lat);
    vectors++;
    if (lat != 5) begin miscompares++; $display("FAIL add_latency: got %0d expected 5", lat); end
    for (int t = 0; t < THREADS; t++) begin
      vectors++;
      if (slot(vdst, t) !== DATA_W'(t - 1)) begin
        miscompares++;
        $display("FAIL add_vdst[%0d]: got %h expected %h", t, slot(vdst, t), DATA_W'(t - 1));
      end
    end
    vectors++;
    if (vdst_wb !== 32'hFFFF_FFFF || vcc_wb !== 1'b0) begin
      miscompares++;
      $display("FAIL add_wb: got wb=%h vcc_wb=%b expected ffffffff/0", vdst_wb, vcc_wb);
    end
    pop();
  endtask

  task automatic test_pass_skip;
    logic [THREADS*DATA_W-1:0] a, b;
    logic [DATA_W-1:0] exp;
    int lat;
    for (int t = 0; t < THREADS; t++) begin
      a[t*DATA_W +: DATA_W] = DATA_W'(t);
      b[t*DATA_W +: DATA_W] = 32'hA5A5_A5A5;
    end
    do_accept(3'd4, a, b, '0, 32'h00FF_0000);
    vectors++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL skip_exec_cycle: got busy=%b out_valid=%b expected 1/0", busy, out_valid);
    end
    wait_valid(lat);
    vectors++;
    if (lat != 2) begin miscompares++; $display("FAIL skip_latency: got %0d expected 2", lat); end
    for (int t = 0; t < THREADS; t++) begin
      exp = (t >= 16 && t <= 23) ? (DATA_W'(t) ^ 32'hA5A5_A5A5) : '0;
      vectors++;
      if (slot(vdst, t) !== exp) begin
        miscompares++;
        $display("FAIL skip_vdst[%0d]: got %h expected %h", t, slot(vdst, t), exp);
      end
    end
    vectors++;
    if (vdst_wb !== 32'h00FF_0000) begin
      miscompares++;
      $display("FAIL skip_wb: got %h expected 00ff0000", vdst_wb);
    end
    pop();
  endtask

  task automatic test_empty_exec;
    int lat;
    do_accept(3'd0, {THREADS{32'h1234_5678}}, {THREADS{32'h1}}, '1, '0);
    wait_valid(lat);
    vectors++;
    if (lat != 1) begin miscompares++; $display("FAIL empty_latency: got %0d expected 1", lat); end
    vectors++;
    if (vdst !== '0 || vdst_wb !== '0 || vcc_wb !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_outputs: got wb=%h vcc_wb=%b nonzero_vdst=%b", vdst_wb, vcc_wb, vdst != '0);
    end
    pop();
  endtask

  task automatic test_compare;
    logic [THREADS*DATA_W-1:0] a, b;
    int lat;
    for (int t = 0; t < THREADS; t++) begin
      a[t*DATA_W +: DATA_W] = DATA_W'(t);
      b[t*DATA_W +: DATA_W] = 32'd16;
    end
    do_accept(3'd6, a, b, '0, 32'h0000_FFFF);
    wait_valid(lat);
    vectors++;
    if (lat != 3) begin miscompares++; $display("FAIL cmp_latency: got %0d expected 3", lat); end
    vectors++;
    if (vcc_data !== 32'h0000_FFFF || sdst_lo !== 32'h0000_FFFF) begin
      miscompares++;
      $display("FAIL cmp_mask: got vcc=%h sdst=%h expected 0000ffff", vcc_data, sdst_lo);
    end
    vectors++;
    if (vcc_wb !== 1'b1 || vdst_wb !== '0 || vdst !== '0) begin
      miscompares++;
      $display("FAIL cmp_wb: got vcc_wb=%b vdst_wb=%h expected 1/0", vcc_wb, vdst_wb);
    end
    pop();
  endtask

  task automatic test_back_to_back;
    logic [THREADS*DATA_W-1:0] a, b;
    int lat, bad;
    for (int t = 0; t < THREADS; t++) begin
      a[t*DATA_W +: DATA_W] = DATA_W'(t) << 8;
      b[t*DATA_W +: DATA_W] = DATA_W'(t);
    end
    do_accept(3'd3, a, b, '0, 32'hFFFF_FFFF);
    wait_valid(lat);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      src0 = '1; src1 = '1; in_valid = 1'b1;
      for (int t = 0; t < THREADS; t++)
        if (slot(vdst, t) !== ((DATA_W'(t) << 8) | DATA_W'(t))) bad++;
      if (!out_valid || !busy || in_ready || vdst_wb !== 32'hFFFF_FFFF) bad++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    vectors++;
    if (bad != 0) begin miscompares++; $display("FAIL hold_stable: got %0d bad samples expected 0", bad); end
    out_ready = 1'b1; #1;
    vectors++;
    if (next_busy !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL pop_next_busy: got next_busy=%b busy=%b expected 0/1", next_busy, busy);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL pop_idle: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    do_accept(3'd2, {THREADS{32'hF0F0_FFFF}}, {THREADS{32'h0FFF_00F0}}, '0, 32'h0000_00FF);
    wait_valid(lat);
    vectors++;
    if (lat != 2 || slot(vdst, 3) !== 32'h00F0_00F0 || vdst_wb !== 32'h0000_00FF) begin
      miscompares++;
      $display("FAIL second_instr: got lat=%0d vdst[3]=%h wb=%h expected 2/00f000f0/000000ff",
               lat, slot(vdst, 3), vdst_wb);
    end
    pop();
  endtask

  task automatic test_edge_ops;
    logic [THREADS*DATA_W-1:0] a, b;
    logic [DATA_W-1:0] exp;
    int lat;
    do_accept(3'd5, {THREADS{32'hFFFF_FFFF}}, {THREADS{32'hFFFF_FFFF}}, '0, 32'h8000_0001);
    wait_valid(lat);
    vectors++;
    if (slot(vdst, 0) !== 32'h1 || slot(vdst, 31) !== 32'h1 || slot(vdst, 5) !== 32'h0) begin
      miscompares++;
      $display("FAIL mul_lo: got %h/%h/%h expected 1/1/0", slot(vdst, 0), slot(vdst, 31), slot(vdst, 5));
    end
    pop();
    for (int t = 0; t < THREADS; t++) begin
      a[t*DATA_W +: DATA_W] = 32'h1000 + DATA_W'(t);
      b[t*DATA_W +: DATA_W] = 32'h2000 + DATA_W'(t);
    end
    do_accept(3'd7, a, b, 32'hAAAA_AAAA, 32'hFFFF_FFFF);
    wait_valid(lat);
    for (int t = 0; t < THREADS; t++) begin
      exp = (t % 2 == 1) ? (32'h2000 + DATA_W'(t)) : (32'h1000 + DATA_W'(t));
      vectors++;
      if (slot(vdst, t) !== exp) begin
        miscompares++;
        $display("FAIL cndmask[%0d]: got %h expected %h", t, slot(vdst, t), exp);
      end
    end
    pop();
  endtask

  task automatic test_reset_mid_exec;
    int seen;
    do_accept(3'd0, {THREADS{32'h5}}, {THREADS{32'h7}}, '0, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if ({in_ready, busy, out_valid} !== 3'b100 || vdst !== '0 || vdst_wb !== '0) begin
      miscompares++;
      $display("FAIL rst_mid: got in_ready/busy/out_valid=%b wb=%h expected 100/0",
               {in_ready, busy, out_valid}, vdst_wb);
    end
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    vectors++;
    if (seen != 0) begin miscompares++; $display("FAIL rst_no_valid: got %0d valid cycles expected 0", seen); end
  endtask

  initial begin
    test_reset();
    test_add_full();
    test_pass_skip();
    test_empty_exec();
    test_compare();
    test_back_to_back();
    test_edge_ops();
    test_reset_mid_exec();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
